// File: rtl/heatmap_frame_source_if.sv
// Producer write/commit bus plus the display word handed to the VGA stage.
interface heatmap_frame_source_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11
);
   logic              i_wr_valid;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [DATA_W-1:0] i_wr_data;
   logic              i_commit;
   logic              o_wr_ready;
   logic              o_wr_err;
   logic              o_commit_pending;
   logic              o_frame_tick;
   logic [DATA_W-1:0] o_display_data;

   modport master (
      output i_wr_valid, i_wr_addr, i_wr_data, i_commit,
      input  o_wr_ready, o_wr_err, o_commit_pending, o_frame_tick, o_display_data
   );

   modport slave (
      input  i_wr_valid, i_wr_addr, i_wr_data, i_commit,
      output o_wr_ready, o_wr_err, o_commit_pending, o_frame_tick, o_display_data
   );
endinterface

// File: rtl/heatmap_frame_source.sv
// Double-buffered 40x30 heatmap cell store replayed as a 16x16-pixel mosaic,
// cycle-aligned to the VGA timing stage through a mirror of its h/v counters.
// H_WRAP is the last h count before wrapping; V_WRAP is the v value that marks
// the frame boundary.
module heatmap_frame_source #(
   parameter int CELLS_X    = 40,
   parameter int CELLS_Y    = 30,
   parameter int CELL_SHIFT = 4,
   parameter int H_LB       = 194,
   parameter int H_UB       = 800,
   parameter int V_LB       = 35,
   parameter int V_UB       = 515,
   parameter int H_WRAP     = 800,
   parameter int V_WRAP     = 525,
   parameter int DATA_W     = 16
) (
   input  logic                   i_clk_25M,
   input  logic                   i_rst_n,
   heatmap_frame_source_if.slave  bus
);

   localparam int CELLS = CELLS_X * CELLS_Y;

   localparam logic [9:0]  H_LB_C    = 10'(H_LB);
   localparam logic [9:0]  H_UB_C    = 10'(H_UB);
   localparam logic [9:0]  V_LB_C    = 10'(V_LB);
   localparam logic [9:0]  V_UB_C    = 10'(V_UB);
   localparam logic [9:0]  H_WRAP_C  = 10'(H_WRAP);
   localparam logic [9:0]  V_WRAP_C  = 10'(V_WRAP);
   localparam logic [10:0] CELLS_C   = 11'(CELLS);
   localparam logic [10:0] CELLS_X_C = 11'(CELLS_X);

   typedef enum logic {T_IDLE, T_RUN} tstate_t;
   typedef enum logic {C_OPEN, C_PENDING} cstate_t;

   tstate_t tstate, tstate_nxt;
   cstate_t cstate, cstate_nxt;

   logic [9:0]  h, v, h_nxt, v_nxt;
   logic        boundary;
   logic        front, front_nxt;
   logic        shown_valid, shown_valid_nxt;
   logic        wr_ready, commit_pending, frame_tick;
   logic        wr_in_range, wr_accept, wr_drop, wr_err_q;
   logic [9:0]  px, py;
   logic        rd_active;
   logic [10:0] rd_addr;

   logic [DATA_W-1:0] mem [2][CELLS];
   logic [DATA_W-1:0] disp_data_p1;

   // Timing state and mirror counters register.
   always_ff @(posedge i_clk_25M) begin
      if (!i_rst_n) begin
         tstate <= T_IDLE;
         h      <= '0;
         v      <= '0;
      end else begin
         tstate <= tstate_nxt;
         h      <= h_nxt;
         v      <= v_nxt;
      end
   end

   // Mirror of the VGA stage counters: one idle cycle, then free-running h/v.
   always_comb begin
      tstate_nxt = tstate;
      h_nxt      = h;
      v_nxt      = v;
      if (tstate == T_IDLE) begin
         tstate_nxt = T_RUN;
      end else begin
         h_nxt = (h == H_WRAP_C) ? 10'd0 : h + 10'd1;
         if (v == V_WRAP_C)
            v_nxt = 10'd0;
         else if (h == H_WRAP_C)
            v_nxt = v + 10'd1;
      end
   end

   assign boundary = (tstate == T_RUN) && (v == V_WRAP_C);

   // Commit FSM and bank-select register.
   always_ff @(posedge i_clk_25M) begin
      if (!i_rst_n) begin
         cstate      <= C_OPEN;
         front       <= 1'b0;
         shown_valid <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         cstate      <= cstate_nxt;
         front       <= front_nxt;
         shown_valid <= shown_valid_nxt;
         wr_err_q    <= wr_drop;
      end
   end

   // Commit FSM: writes open until a commit, swap banks at the next boundary.
   always_comb begin
      cstate_nxt      = cstate;
      front_nxt       = front;
      shown_valid_nxt = shown_valid;
      wr_ready        = 1'b0;
      commit_pending  = 1'b0;
      frame_tick      = 1'b0;
      case (cstate)
         C_OPEN: begin
            wr_ready = 1'b1;
            if (bus.i_commit)
               cstate_nxt = C_PENDING;
         end
         C_PENDING: begin
            commit_pending = 1'b1;
            if (boundary) begin
               frame_tick      = 1'b1;
               front_nxt       = ~front;
               shown_valid_nxt = 1'b1;
               cstate_nxt      = C_OPEN;
            end
         end
         default: cstate_nxt = C_OPEN;
      endcase
   end

   // Write decode: in-range writes land in the back bank, others are flagged.
   always_comb begin
      wr_in_range = bus.i_wr_addr < CELLS_C;
      wr_accept   = bus.i_wr_valid && wr_ready && wr_in_range;
      wr_drop     = bus.i_wr_valid && wr_ready && !wr_in_range;
   end

   // Back-bank write port; cell storage is never cleared.
   always_ff @(posedge i_clk_25M) begin
      if (i_rst_n && wr_accept)
         mem[!front][bus.i_wr_addr] <= bus.i_wr_data;
   end

   // Read address from next-state counters so the registered word lines up
   // with the pixel the mirror counters reach at the same edge.
   always_comb begin
      px        = h_nxt - H_LB_C;
      py        = v_nxt - V_LB_C;
      rd_active = (tstate_nxt == T_RUN) &&
                  (h_nxt >= H_LB_C) && (h_nxt <= H_UB_C) &&
                  (v_nxt >= V_LB_C) && (v_nxt <  V_UB_C);
      rd_addr   = 11'(py >> CELL_SHIFT) * CELLS_X_C + 11'(px >> CELL_SHIFT);
   end

   // ---- stage p1: registered front-bank read, blanked outside the active area
   always_ff @(posedge i_clk_25M) begin
      if (!i_rst_n)
         disp_data_p1 <= '0;
      else if (rd_active && shown_valid_nxt)
         disp_data_p1 <= mem[front_nxt][rd_addr];
      else
         disp_data_p1 <= '0;
   end

   assign bus.o_wr_ready       = wr_ready;
   assign bus.o_wr_err         = wr_err_q;
   assign bus.o_commit_pending = commit_pending;
   assign bus.o_frame_tick     = frame_tick;
   assign bus.o_display_data   = disp_data_p1;

endmodule

// File: tb/tb_heatmap_frame_source.sv
// Scoreboard bench for heatmap_frame_source on a shortened raster
// (h wraps at 211, boundary at v==52) keeping the real active-area origin.
module tb_heatmap_frame_source;
   localparam int HW = 211;
   localparam int VW = 52;
   localparam int L  = HW + 1;
   // Boundaries are VW*L cycles apart: v clears while h steps to 1, so line 0
   // after a boundary is one cycle short and the boundary cycle makes it up.
   localparam int F  = VW * L;

   localparam int K_DISP  = 0;
   localparam int K_READY = 1;
   localparam int K_ERR   = 2;
   localparam int K_PEND  = 3;
   localparam int K_TICK  = 4;

   typedef struct {
      int          t;
      int          kind;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] mon_act;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tcyc  = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   heatmap_frame_source_if hm_bus ();

   heatmap_frame_source #(
      .H_UB   (211),
      .V_UB   (52),
      .H_WRAP (HW),
      .V_WRAP (VW)
   ) dut (
      .i_clk_25M (clk),
      .i_rst_n   (rst_n),
      .bus       (hm_bus)
   );

   always #20 clk = ~clk;
   always @(posedge clk) tcyc <= tcyc + 1;

   // cycle (relative to release) of pixel (h,v) in frame f, and of boundary b
   function automatic int kpix(input int f, input int h, input int v);
      return f * F + v * L + h + 1;
   endfunction

   function automatic int kbnd(input int b);
      return b * F + 1;
   endfunction

   task automatic expect_at(input int t, input int kind, input logic [15:0] val, input string name);
      exp_t e;
      int   i;
      e.t = t; e.kind = kind; e.val = val; e.name = name;
      i = sb.size();
      while (i > 0 && sb[i-1].t > t) i--;
      sb.insert(i, e);
   endtask

   task automatic goto(input int t);
      if (tcyc > t) begin
         $display("FAIL schedule: at cycle %0d, required cycle %0d", tcyc, t);
         $fatal(1, "stimulus schedule overrun");
      end
      while (tcyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic write_cell(input int t, input logic [10:0] addr, input logic [15:0] data);
      goto(t);
      hm_bus.i_wr_valid = 1'b1;
      hm_bus.i_wr_addr  = addr;
      hm_bus.i_wr_data  = data;
      goto(t + 1);
      hm_bus.i_wr_valid = 1'b0;
   endtask

   task automatic commit_at(input int t);
      goto(t);
      hm_bus.i_commit = 1'b1;
      goto(t + 1);
      hm_bus.i_commit = 1'b0;
   endtask

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].t <= tcyc) begin
         mon_e = sb.pop_front();
         case (mon_e.kind)
            K_DISP:  mon_act = hm_bus.o_display_data;
            K_READY: mon_act = 16'(hm_bus.o_wr_ready);
            K_ERR:   mon_act = 16'(hm_bus.o_wr_err);
            K_PEND:  mon_act = 16'(hm_bus.o_commit_pending);
            default: mon_act = 16'(hm_bus.o_frame_tick);
         endcase
         n_checks++;
         if (mon_e.t != tcyc)
            $display("FAIL %s: due at cycle %0d, reached at %0d", mon_e.name, mon_e.t, tcyc);
         else if (mon_act !== mon_e.val)
            $display("FAIL %s: cycle %0d got %h expected %h", mon_e.name, tcyc, mon_act, mon_e.val);
         else
            n_pass++;
      end
   end

   initial begin
      #(40 * 90000);
      $display("FAIL watchdog: run exceeded 90000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, base2, w;
      hm_bus.i_wr_valid = 1'b0;
      hm_bus.i_wr_addr  = '0;
      hm_bus.i_wr_data  = '0;
      hm_bus.i_commit   = 1'b0;
      expect_at(2, K_DISP,  16'h0, "rst_disp");
      expect_at(2, K_READY, 16'h1, "rst_ready");
      expect_at(2, K_PEND,  16'h0, "rst_pend");
      @(posedge clk); #1;
      goto(4);
      rst_n = 1'b1;
      base  = tcyc;

      // release cycle and frame 0 (nothing published yet)
      expect_at(base, K_DISP,  16'h0, "idle_disp");
      expect_at(base, K_READY, 16'h1, "idle_ready");
      expect_at(base, K_ERR,   16'h0, "idle_err");
      expect_at(base, K_PEND,  16'h0, "idle_pend");
      expect_at(base, K_TICK,  16'h0, "idle_tick");
      expect_at(base + kpix(0, 194, 35), K_DISP, 16'h0, "f0_194_35");
      expect_at(base + kpix(0, 210, 35), K_DISP, 16'h0, "f0_210_35");
      expect_at(base + kpix(0, 194, 51), K_DISP, 16'h0, "f0_194_51");
      expect_at(base + 2,  K_READY, 16'h1, "open_ready");
      expect_at(base + 5,  K_ERR,   16'h0, "oor_err_pre");
      expect_at(base + 6,  K_ERR,   16'h1, "oor_err_pulse");
      expect_at(base + 7,  K_ERR,   16'h0, "oor_err_post");
      expect_at(base + 10, K_PEND,  16'h0, "commit_pend_pre");
      expect_at(base + 11, K_PEND,  16'h1, "commit_pend");
      expect_at(base + 11, K_READY, 16'h0, "pend_ready");
      expect_at(base + 12, K_READY, 16'h0, "pend_ready2");
      expect_at(base + 13, K_ERR,   16'h0, "pend_err");
      expect_at(base + kbnd(1) - 1, K_TICK,  16'h0, "b1_tick_pre");
      expect_at(base + kbnd(1),     K_TICK,  16'h1, "b1_tick");
      expect_at(base + kbnd(1),     K_PEND,  16'h1, "b1_pend");
      expect_at(base + kbnd(1) + 1, K_PEND,  16'h0, "b1_pend_post");
      expect_at(base + kbnd(1) + 1, K_READY, 16'h1, "b1_ready_post");

      // frame 1 shows A
      expect_at(base + kpix(1, 194, 35), K_DISP, 16'h1234, "f1_194_35");
      expect_at(base + kpix(1, 209, 35), K_DISP, 16'h1234, "f1_209_35");
      expect_at(base + kpix(1, 210, 35), K_DISP, 16'hABCD, "f1_210_35");
      expect_at(base + kpix(1, 194, 51), K_DISP, 16'h00FF, "f1_194_51");
      expect_at(base + kpix(1, 193, 35), K_DISP, 16'h0,    "f1_193_35");
      expect_at(base + kpix(1, 194, 34), K_DISP, 16'h0,    "f1_194_34");

      // commit on boundary 2 swaps only at boundary 3
      expect_at(base + kbnd(2),         K_TICK, 16'h0, "b2_tick");
      expect_at(base + kbnd(2),         K_PEND, 16'h0, "b2_pend");
      expect_at(base + kbnd(2) + 1,     K_PEND, 16'h1, "b2_pend_post");
      expect_at(base + kpix(2, 194, 35), K_DISP, 16'h1234, "f2_194_35");
      expect_at(base + kbnd(2) + F / 2, K_PEND, 16'h1, "f2_pend_mid");
      expect_at(base + kbnd(3) - 1,     K_TICK, 16'h0, "b3_tick_pre");
      expect_at(base + kbnd(3),         K_TICK, 16'h1, "b3_tick");
      expect_at(base + kbnd(3),         K_PEND, 16'h1, "b3_pend");
      expect_at(base + kbnd(3) + 1,     K_PEND, 16'h0, "b3_pend_post");

      // frame 3 shows B, frame 4 shows A again from the old front bank
      expect_at(base + kpix(3, 194, 35), K_DISP, 16'h5555, "f3_194_35");
      expect_at(base + kpix(3, 210, 35), K_DISP, 16'h6666, "f3_210_35");
      expect_at(base + kpix(3, 194, 51), K_DISP, 16'h7777, "f3_194_51");
      expect_at(base + kpix(3, 200, 51) + 1, K_PEND, 16'h1, "f3_commit_pend");
      expect_at(base + kbnd(4),          K_TICK, 16'h1, "b4_tick");
      expect_at(base + kpix(4, 194, 35), K_DISP, 16'h1234, "f4_194_35");
      expect_at(base + kpix(4, 210, 35), K_DISP, 16'hABCD, "f4_210_35");

      // mid-frame reset while pending
      w = base + kpix(4, 200, 40);
      expect_at(w,     K_DISP,  16'h1234, "prerst_disp");
      expect_at(w,     K_PEND,  16'h1,    "prerst_pend");
      expect_at(w + 1, K_DISP,  16'h0,    "mrst_disp");
      expect_at(w + 1, K_READY, 16'h1,    "mrst_ready");
      expect_at(w + 1, K_ERR,   16'h0,    "mrst_err");
      expect_at(w + 1, K_PEND,  16'h0,    "mrst_pend");
      expect_at(w + 1, K_TICK,  16'h0,    "mrst_tick");
      expect_at(w + 2, K_PEND,  16'h0,    "mrst_pend2");

      write_cell(base + 2, 11'd0, 16'h1234);
      write_cell(base + 3, 11'd1, 16'hABCD);
      write_cell(base + 5, 11'd1200, 16'hBEEF);
      goto(base + 10);
      hm_bus.i_wr_valid = 1'b1;
      hm_bus.i_wr_addr  = 11'd40;
      hm_bus.i_wr_data  = 16'h00FF;
      hm_bus.i_commit   = 1'b1;
      goto(base + 11);
      hm_bus.i_wr_valid = 1'b0;
      hm_bus.i_commit   = 1'b0;
      write_cell(base + 12, 11'd0, 16'hDEAD);

      write_cell(base + kbnd(1) + 10, 11'd0,  16'h5555);
      write_cell(base + kbnd(1) + 11, 11'd1,  16'h6666);
      write_cell(base + kbnd(1) + 12, 11'd40, 16'h7777);
      commit_at(base + kbnd(2));
      commit_at(base + kpix(3, 200, 51));
      commit_at(base + kpix(4, 0, 36));

      goto(w);
      rst_n = 1'b0;
      goto(w + 3);
      rst_n = 1'b1;
      base2 = tcyc;

      // after reset nothing is shown until a new commit
      expect_at(base2 + kpix(0, 194, 35), K_DISP, 16'h0, "r_f0_194_35");
      expect_at(base2 + kpix(0, 210, 35), K_DISP, 16'h0, "r_f0_210_35");
      expect_at(base2 + kpix(0, 194, 51), K_DISP, 16'h0, "r_f0_194_51");
      expect_at(base2 + kbnd(1),          K_TICK, 16'h0, "r_b1_tick");
      expect_at(base2 + kbnd(1),          K_PEND, 16'h0, "r_b1_pend");

      goto(base2 + kbnd(1) + 2);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
